// File: rtl/scp_pkg.sv
// Shared state encodings and parameter defaults for the scp_079_multi block.
package scp_pkg;

    // FSM state codes; 6 and 7 are unused and recover to IDLE.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_OK      = 3'd1;
    localparam logic [2:0] S_ATTACK  = 3'd2;
    localparam logic [2:0] S_TAMPER  = 3'd3;
    localparam logic [2:0] S_LOCK    = 3'd4;
    localparam logic [2:0] S_RECOVER = 3'd5;

    // Parameter defaults.
    localparam int TIMER_W_DEF     = 6;
    localparam int N_ALARM_DEF     = 3;
    localparam int T_ATTACK_DEF    = 40;
    localparam int T_ESC_DEF       = 8;
    localparam int T_RECOVER_DEF   = 20;
    localparam int CHEAT_LIMIT_DEF = 3;

endpackage

// File: rtl/scp_phase_timer.sv
// Saturating per-phase cycle counter with synchronous clear and hold.
module scp_phase_timer #(
    parameter int TIMER_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               hold,
    output logic [TIMER_W-1:0] count
);

    // Clear wins over hold; counting stops at all ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (!hold && count != '1)
            count <= count + TIMER_W'(1);
    end

endmodule

// File: rtl/scp_079_multi.sv
// Status monitor FSM: tracks green/yellow/red levels through attack,
// tamper, lockdown and recovery phases, drives a thermometer alarm and
// honours a limited number of cheat (override) requests.
module scp_079_multi
    import scp_pkg::*;
#(
    parameter int TIMER_W     = TIMER_W_DEF,
    parameter int N_ALARM     = N_ALARM_DEF,
    parameter int T_ATTACK    = T_ATTACK_DEF,
    parameter int T_ESC       = T_ESC_DEF,
    parameter int T_RECOVER   = T_RECOVER_DEF,
    parameter int CHEAT_LIMIT = CHEAT_LIMIT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               green,
    input  logic               yellow,
    input  logic               red,
    input  logic               cheat_in,
    output logic [2:0]         state,
    output logic [TIMER_W-1:0] timer,
    output logic [N_ALARM-1:0] alarm,
    output logic               cheat_out,
    output logic               err
);

    localparam int T_MAX = (1 << TIMER_W) - 1;
    localparam int LVL_W = $clog2(N_ALARM + 1);
    localparam int CNT_W = (CHEAT_LIMIT < 1) ? 1 : $clog2(CHEAT_LIMIT + 1);

    localparam logic [TIMER_W-1:0] ATTACK_LAST  = TIMER_W'(T_ATTACK - 1);
    localparam logic [TIMER_W-1:0] ESC_LAST     = TIMER_W'(T_ESC - 1);
    localparam logic [TIMER_W-1:0] RECOVER_LAST = TIMER_W'(T_RECOVER - 1);
    localparam logic [LVL_W-1:0]   LVL_MAX      = LVL_W'(N_ALARM);
    localparam logic [CNT_W-1:0]   CNT_MAX      = CNT_W'(CHEAT_LIMIT);

    // Phase lengths must be reachable by the saturating timer.
    if (T_ATTACK > T_MAX || T_ESC > T_MAX || T_RECOVER > T_MAX) begin : g_bad_timing
        $error("scp_079_multi: phase length exceeds timer range");
    end

    logic [2:0]         state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [TIMER_W-1:0] esc_q, esc_d;
    logic [CNT_W-1:0]   cheats_q, cheats_d;
    logic [N_ALARM-1:0] alarm_d;
    logic               cheat_d, err_d;
    logic               hold, clear, one_hot;

    assign one_hot = ({green, yellow, red} == 3'b100) ||
                     ({green, yellow, red} == 3'b010) ||
                     ({green, yellow, red} == 3'b001);

    // Lowest (lvl+1) alarm bits set; naturally capped at all ones.
    function automatic logic [N_ALARM-1:0] therm(input logic [LVL_W-1:0] lvl);
        logic [N_ALARM-1:0] t;
        for (int i = 0; i < N_ALARM; i++)
            t[i] = (i <= int'(lvl));
        return t;
    endfunction

    // Next-state, cheat bookkeeping and escalation decisions.
    always_comb begin
        state_d  = state;
        level_d  = level_q;
        esc_d    = esc_q;
        cheats_d = cheats_q;
        cheat_d  = 1'b0;
        err_d    = 1'b0;
        hold     = 1'b0;

        case (state)
            S_IDLE: state_d = S_OK;
            S_OK, S_ATTACK, S_TAMPER, S_LOCK, S_RECOVER: begin
                if (!one_hot) begin
                    // Ambiguous status: flag it and freeze this cycle.
                    err_d = 1'b1;
                    hold  = 1'b1;
                end else if (red) begin
                    state_d = S_LOCK;
                end else begin
                    // Cheats only matter while under attack.
                    if (cheat_in && (state == S_ATTACK || state == S_TAMPER)) begin
                        if (cheats_q < CNT_MAX) begin
                            state_d  = S_RECOVER;
                            cheat_d  = 1'b1;
                            cheats_d = cheats_q + CNT_W'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (!cheat_d) begin
                        case (state)
                            S_OK:
                                if (yellow) state_d = S_ATTACK;
                            S_ATTACK:
                                if (green)
                                    state_d = S_RECOVER;
                                else if (timer == ATTACK_LAST)
                                    state_d = S_TAMPER;
                            S_TAMPER:
                                if (green) state_d = S_RECOVER;
                            S_LOCK:
                                if (green) state_d = S_RECOVER;
                            S_RECOVER:
                                if (yellow)
                                    state_d = S_ATTACK;
                                else if (timer == RECOVER_LAST)
                                    state_d = S_OK;
                            default: state_d = state;
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Escalation only runs while staying in TAMPER; leaving resets it.
        if (state_d != S_TAMPER) begin
            level_d = '0;
            esc_d   = '0;
        end else if (state == S_TAMPER && !hold) begin
            if (esc_q == ESC_LAST) begin
                esc_d = '0;
                if (level_q != LVL_MAX)
                    level_d = level_q + LVL_W'(1);
            end else begin
                esc_d = esc_q + TIMER_W'(1);
            end
        end
    end

    assign clear = (state_d != state);

    // Alarm is computed from the next state so it lines up with state.
    always_comb begin
        alarm_d = '0;
        case (state_d)
            S_ATTACK: alarm_d[0] = 1'b1;
            S_TAMPER: alarm_d = therm(level_d);
            S_LOCK:   alarm_d = '1;
            default:  alarm_d = '0;
        endcase
    end

    // All outputs and bookkeeping registered; reset clears everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            level_q   <= '0;
            esc_q     <= '0;
            cheats_q  <= '0;
            alarm     <= '0;
            cheat_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            level_q   <= level_d;
            esc_q     <= esc_d;
            cheats_q  <= cheats_d;
            alarm     <= alarm_d;
            cheat_out <= cheat_d;
            err       <= err_d;
        end
    end

    scp_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .hold  (hold),
        .count (timer)
    );

endmodule

// File: tb/tb_scp_079_multi.sv
// Directed bench for scp_079_multi with default parameters.
module tb_scp_079_multi;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       green = 1'b1, yellow = 1'b0, red = 1'b0, cheat_in = 1'b0;
    logic [2:0] state;
    logic [5:0] timer;
    logic [2:0] alarm;
    logic       cheat_out, err;

    int n_chk  = 0;
    int n_pass = 0;

    scp_079_multi dut (
        .clock     (clock),
        .reset     (reset),
        .green     (green),
        .yellow    (yellow),
        .red       (red),
        .cheat_in  (cheat_in),
        .state     (state),
        .timer     (timer),
        .alarm     (alarm),
        .cheat_out (cheat_out),
        .err       (err)
    );

    always #500 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic lvl(input logic g, input logic y, input logic r);
        green = g; yellow = y; red = r;
    endtask

    // From ATTACK_DB with yellow held: one cheat attempt and its aftermath.
    task automatic cheat_try(input string tag, input logic honoured);
        cheat_in = 1'b1;
        tick(1);
        cheat_in = 1'b0;
        if (honoured) begin
            chk({tag, "_state"}, state, 5);
            chk({tag, "_cout"}, cheat_out, 1);
            chk({tag, "_err"}, err, 0);
            tick(1);
            chk({tag, "_back"}, state, 2);
            chk({tag, "_pulse"}, cheat_out, 0);
        end else begin
            chk({tag, "_state"}, state, 2);
            chk({tag, "_cout"}, cheat_out, 0);
            chk({tag, "_err"}, err, 1);
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_state", state, 0);
        chk("rst_timer", timer, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_cout", cheat_out, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        chk("idle", state, 0);
        tick(1);
        chk("ok_state", state, 1);
        chk("ok_timer", timer, 0);
        tick(70);
        chk("ok_sat_timer", timer, 63);
        chk("ok_alarm", alarm, 0);

        // Attack, tamper escalation, recovery
        lvl(0, 1, 0);
        tick(1);
        chk("atk_state", state, 2);
        chk("atk_alarm", alarm, 1);
        chk("atk_timer", timer, 0);
        tick(39);
        chk("atk_39", state, 2);
        chk("atk_t39", timer, 39);
        tick(1);
        chk("tmp_state", state, 3);
        chk("tmp_alarm0", alarm, 3'b001);
        tick(7);
        chk("tmp_alarm7", alarm, 3'b001);
        tick(1);
        chk("tmp_alarm8", alarm, 3'b011);
        tick(8);
        chk("tmp_alarm16", alarm, 3'b111);
        tick(8);
        chk("tmp_alarm24", alarm, 3'b111);
        lvl(1, 0, 0);
        tick(1);
        chk("rec_state", state, 5);
        chk("rec_alarm", alarm, 0);
        tick(19);
        chk("rec_19", state, 5);
        tick(1);
        chk("rec_ok", state, 1);

        // Red during RECOVER at timer 10
        lvl(0, 1, 0); tick(1);
        lvl(1, 0, 0); tick(1);
        chk("rec2_state", state, 5);
        tick(10);
        chk("rec2_t10", timer, 10);
        lvl(0, 0, 1); tick(1);
        chk("lock_state", state, 4);
        chk("lock_alarm", alarm, 3'b111);
        chk("lock_timer", timer, 0);
        lvl(0, 0, 1); cheat_in = 1'b1; tick(1); cheat_in = 1'b0;
        chk("lock_cheat_ign", state, 4);
        chk("lock_cheat_err", err, 0);

        // Cheat limit
        lvl(1, 0, 0); tick(1);
        lvl(0, 1, 0); tick(1);
        chk("cht_atk", state, 2);
        cheat_try("cheat1", 1);
        cheat_try("cheat2", 1);
        cheat_try("cheat3", 1);
        cheat_try("cheat4", 0);
        chk("cheat4_timer", timer, 1);

        // Non one-hot status in OK holds state and timer
        lvl(1, 0, 0); tick(1);
        tick(20);
        chk("ok2_state", state, 1);
        tick(2);
        chk("ok2_t2", timer, 2);
        lvl(1, 1, 0); tick(1);
        chk("inv_err", err, 1);
        chk("inv_state", state, 1);
        chk("inv_timer", timer, 2);
        lvl(1, 0, 0); tick(1);
        chk("inv_err_clr", err, 0);
        chk("inv_timer_run", timer, 3);

        // Reset mid-TAMPER, asynchronous
        lvl(0, 1, 0); tick(41);
        chk("tmp2_state", state, 3);
        tick(10);
        chk("tmp2_alarm", alarm, 3'b011);
        #100 reset = 1'b1;
        #10;
        chk("arst_state", state, 0);
        chk("arst_timer", timer, 0);
        chk("arst_alarm", alarm, 0);
        reset = 1'b0;
        tick(1);
        chk("arst_ok", state, 1);
        tick(1);
        chk("arst_atk", state, 2);
        cheat_try("cnt_restart", 1);

        // Red together with cheat in TAMPER
        tick(40);
        chk("tmp3_state", state, 3);
        lvl(0, 0, 1); cheat_in = 1'b1; tick(1); cheat_in = 1'b0;
        chk("redcheat_state", state, 4);
        chk("redcheat_cout", cheat_out, 0);
        chk("redcheat_alarm", alarm, 3'b111);
        // Count is 1: two more honoured, then refused
        lvl(1, 0, 0); tick(1);
        lvl(0, 1, 0); tick(1);
        cheat_try("post2", 1);
        cheat_try("post3", 1);
        cheat_try("post4", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout got=%0d exp=%0d", n_chk, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/scp_079_multi.md
SCP_079_MULTI -- requirements
Module: scp_079_multi

Interface
REQ-001 Parameter TIMER_W, default 6: width of the phase timer.
REQ-002 Parameter N_ALARM, default 3: number of alarm channels.
REQ-003 Parameter T_ATTACK, default 40: cycles of held yellow before ATTACK_DB escalates to TAMPER.
REQ-004 Parameter T_ESC, default 8: cycles per alarm escalation step in TAMPER.
REQ-005 Parameter T_RECOVER, default 20: cycles of held green in RECOVER before returning to OK.
REQ-006 Parameter CHEAT_LIMIT, default 3: maximum honoured cheat requests between resets.
REQ-007 Port clock, input, 1 bit: sole clock, rising-edge active.
REQ-008 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 Ports green, yellow, red, input, 1 bit each: status levels, expected one-hot.
REQ-010 Port cheat_in, input, 1 bit: cheat/override request, sampled each cycle.
REQ-011 Port state, output, 3 bits: current FSM state encoding.
REQ-012 Port timer, output, TIMER_W bits: cycles spent in the current state.
REQ-013 Port alarm, output, N_ALARM bits: thermometer-coded alarm channels.
REQ-014 Port cheat_out, output, 1 bit: one-cycle pulse when a cheat is honoured.
REQ-015 Port err, output, 1 bit: one-cycle pulse on an invalid input or a refused cheat.

Function
REQ-016 State encodings SHALL be IDLE=0, OK=1, ATTACK_DB=2, TAMPER=3, LOCKDOWN=4, RECOVER=5; codes 6 and 7 SHALL go to IDLE on the next cycle.
REQ-017 IDLE SHALL go to OK unconditionally after one cycle.
REQ-018 Priority in every state except IDLE SHALL be: red, then cheat, then yellow, then green.
REQ-019 A status vector that is not one-hot SHALL pulse err, hold state and hold timer for that cycle.
REQ-020 OK transitions: red -> LOCKDOWN; yellow -> ATTACK_DB; green -> stay.
REQ-021 ATTACK_DB transitions: red -> LOCKDOWN; green -> RECOVER; yellow held with timer==T_ATTACK-1 -> TAMPER.
REQ-022 TAMPER transitions: red -> LOCKDOWN; green -> RECOVER; otherwise stay and raise the escalation level by one every T_ESC cycles, saturating at N_ALARM.
REQ-023 LOCKDOWN transitions: green -> RECOVER; otherwise stay.
REQ-024 RECOVER transitions: red -> LOCKDOWN; yellow -> ATTACK_DB; green held with timer==T_RECOVER-1 -> OK.
REQ-025 timer SHALL clear to 0 on every state change, otherwise increment once per cycle, saturating at 2^TIMER_W-1.
REQ-026 Alarm mapping SHALL be registered: IDLE, OK and RECOVER = all zeros; ATTACK_DB = bit0 only; TAMPER = lowest (level+1) bits set, capped at all ones; LOCKDOWN = all ones.
REQ-027 cheat_in in ATTACK_DB or TAMPER with fewer than CHEAT_LIMIT honoured cheats SHALL go to RECOVER, pulse cheat_out and increment the cheat count.
REQ-028 cheat_in when the cheat count equals CHEAT_LIMIT SHALL pulse err and otherwise be ignored.
REQ-029 cheat_in in IDLE, OK, LOCKDOWN or RECOVER SHALL be ignored without an err pulse.
REQ-030 Cheat and red asserted in the same cycle SHALL resolve to red: LOCKDOWN, with no cheat_out and no count change.
REQ-031 Every output SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-032 Reset assertion SHALL immediately force state=IDLE, timer=0, alarm=0, cheat_out=0, err=0, escalation level=0 and cheat count=0, including mid-phase.
REQ-033 The cheat count SHALL clear only on reset.

Structure
REQ-034 Package scp_pkg SHALL hold the state encodings and the parameter defaults.
REQ-035 Sub-module scp_phase_timer SHALL implement the saturating counter with synchronous clear, parametrised by TIMER_W.
REQ-036 Elaboration SHALL fail if T_ATTACK, T_ESC or T_RECOVER exceeds 2^TIMER_W-1.

Verification (defaults; clock period 1000 time units)
REQ-037 Reset, then green held -> IDLE for 1 cycle, then OK; alarm=000; timer saturates at 63.
REQ-038 Green, then yellow for 40 cycles, then green -> ATTACK_DB with alarm=001; TAMPER at cycle 40; alarm goes 001, 011, 111 at 8-cycle steps; then RECOVER, and OK after 20 green cycles.
REQ-039 Red during RECOVER at timer=10 -> LOCKDOWN next cycle, alarm=111, timer=0.
REQ-040 Four cheat pulses, each in ATTACK_DB -> the first three give cheat_out plus RECOVER; the fourth gives err and stays in ATTACK_DB.
REQ-041 green=yellow=1 for one cycle in OK -> err=1, state=OK, timer held; red together with cheat_in in TAMPER -> LOCKDOWN, cheat_out=0.
REQ-042 Reset asserted mid-TAMPER -> all outputs zero without waiting for a clock edge; the cheat count restarts at 0.
